// File: rtl/bsg_arb_rr_burst_lock.sv
// Round-robin arbiter that holds its grant for a whole multi-beat burst.
// Priority rotates once per burst; a beat-count limit forces release of a stuck owner.
module bsg_arb_rr_burst_lock #(
  parameter  int width_p      = 4,
  parameter  int max_burst_p  = 8,
  localparam int lg_width_lp  = (width_p > 1) ? $clog2(width_p) : 1,
  localparam int cnt_width_lp = $clog2(max_burst_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     reqs_i,
  input  logic                   last_i,
  input  logic                   yumi_i,
  output logic [width_p-1:0]     grants_o,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] tag_o,
  output logic                   locked_o,
  output logic                   overrun_o
);

  typedef enum logic {IDLE, LOCKED} mode_e;

  mode_e                   mode_q, mode_d;
  logic [lg_width_lp-1:0]  owner_q, owner_d;
  logic [lg_width_lp-1:0]  last_q, last_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    overrun_q, overrun_d;

  logic [lg_width_lp-1:0]  win_idx, cand;
  logic                    win_found;
  logic [width_p-1:0]      owner_oh, win_oh, grants_raw;
  logic                    accept;

  // Scan starts just past the last burst's owner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= width_p; i++) begin
      cand = lg_width_lp'((int'(last_q) + i) % width_p);
      if (!win_found && reqs_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < width_p; gi++) begin : g_onehot
    assign owner_oh[gi] = (owner_q == lg_width_lp'(gi));
    assign win_oh[gi]   = win_found && (win_idx == lg_width_lp'(gi));
  end

  assign grants_raw = (mode_q == LOCKED) ? (owner_oh & reqs_i) : win_oh;
  assign grants_o   = reset_i ? '0 : grants_raw;
  assign v_o        = |grants_o;
  assign tag_o      = !v_o ? '0 : ((mode_q == LOCKED) ? owner_q : win_idx);
  assign locked_o   = (mode_q == LOCKED);
  assign overrun_o  = overrun_q;
  assign accept     = v_o & yumi_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q    <= IDLE;
      owner_q   <= '0;
      last_q    <= lg_width_lp'(width_p - 1);
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // overrun is a single-cycle pulse, so it defaults low on every edge.
  always_comb begin
    mode_d    = mode_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    unique case (mode_q)
      IDLE: begin
        if (accept) begin
          last_d = win_idx;
          if (!last_i) begin
            mode_d  = LOCKED;
            owner_d = win_idx;
            cnt_d   = cnt_width_lp'(1);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (last_i) begin
            mode_d = IDLE;
            cnt_d  = '0;
          end else if (cnt_q == cnt_width_lp'(max_burst_p - 1)) begin
            mode_d    = IDLE;
            cnt_d     = '0;
            overrun_d = 1'b1;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      default: mode_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bsg_arb_rr_burst_lock.sv
// Bench for bsg_arb_rr_burst_lock: directed scenarios plus a constrained-random run,
// checked each cycle against a burst-level model of the arbitration rules.
module tb_bsg_arb_rr_burst_lock;
  localparam int W    = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] reqs4, grants4;
  logic         last4, yumi4, v4, locked4, ovr4;
  logic [1:0]   tag4;

  logic [0:0]   reqs1, grants1, tag1;
  logic         last1, yumi1, v1, locked1, ovr1;

  bsg_arb_rr_burst_lock #(.width_p(W), .max_burst_p(MAXB)) dut (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs4), .last_i(last4), .yumi_i(yumi4),
    .grants_o(grants4), .v_o(v4), .tag_o(tag4), .locked_o(locked4), .overrun_o(ovr4));

  bsg_arb_rr_burst_lock #(.width_p(1), .max_burst_p(MAXB)) dut1 (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs1), .last_i(last1), .yumi_i(yumi1),
    .grants_o(grants1), .v_o(v1), .tag_o(tag1), .locked_o(locked1), .overrun_o(ovr1));

  int tests_run = 0;
  int failures  = 0;
  bit cmp_en    = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: busy burst, its owner, the requester with top priority next, beats taken.
  int m_busy, m_owner, m_ptr, m_beats, m_ovr;

  function automatic int m_win(logic [W-1:0] r, int busy, int owner, int ptr);
    if (busy != 0) return (((r >> owner) & 4'b1) != 0) ? owner : -1;
    for (int k = 0; k < W; k++) begin
      int i;
      i = (ptr + k) % W;
      if (((r >> i) & 4'b1) != 0) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_owner <= 0; m_ptr <= 0; m_beats <= 0; m_ovr <= 0;
    end else begin
      m_ovr <= 0;
      if (m_win(reqs4, m_busy, m_owner, m_ptr) >= 0 && yumi4) begin
        if (m_busy == 0) begin
          m_ptr <= (m_win(reqs4, m_busy, m_owner, m_ptr) + 1) % W;
          if (!last4) begin
            m_busy  <= 1;
            m_owner <= m_win(reqs4, m_busy, m_owner, m_ptr);
            m_beats <= 1;
          end
        end else if (last4) begin
          m_busy <= 0;
        end else if (m_beats + 1 == MAXB) begin
          m_busy <= 0;
          m_ovr  <= 1;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (cmp_en) begin
      w = rst ? -1 : m_win(reqs4, m_busy, m_owner, m_ptr);
      chk("cmp_grants", int'(grants4), (w >= 0) ? (1 << w) : 0);
      chk("cmp_v", int'(v4), (w >= 0) ? 1 : 0);
      chk("cmp_tag", int'(tag4), (w >= 0) ? w : 0);
      chk("cmp_locked", int'(locked4), rst ? 0 : m_busy);
      chk("cmp_overrun", int'(ovr4), rst ? 0 : m_ovr);
    end
  end

  task automatic step(input logic [W-1:0] r, input logic l, input logic y);
    @(posedge clk); #1;
    reqs4 = r; last4 = l; yumi4 = y;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; reqs4 = '0; last4 = 1'b0; yumi4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int exp_rot[5] = '{1, 2, 4, 8, 1};
  logic [W-1:0] rr;

  initial begin
    rst = 1'b0; reqs4 = '0; last4 = 1'b0; yumi4 = 1'b0;
    reqs1 = '0; last1 = 1'b0; yumi1 = 1'b0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("reset_grants", int'(grants4), 0);
    chk("reset_locked", int'(locked4), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Rotation with single-beat bursts.
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk($sformatf("rot_grant%0d", k), int'(grants4), exp_rot[k]);
      chk($sformatf("rot_tag%0d", k), int'(tag4), k % 4);
      chk($sformatf("rot_locked%0d", k), int'(locked4), 0);
    end

    // Burst lock holds requester 0 across three beats.
    do_reset();
    step(4'b0101, 1'b0, 1'b1); chk("lock_g1", int'(grants4), 1); chk("lock_l1", int'(locked4), 0);
    step(4'b0101, 1'b0, 1'b1); chk("lock_g2", int'(grants4), 1); chk("lock_l2", int'(locked4), 1);
    step(4'b0101, 1'b1, 1'b1); chk("lock_g3", int'(grants4), 1); chk("lock_l3", int'(locked4), 1);
    step(4'b0101, 1'b0, 1'b0); chk("lock_g4", int'(grants4), 4); chk("lock_l4", int'(locked4), 0);

    // Stall: nothing rotates without yumi.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b0110, 1'b0, 1'b0);
      chk($sformatf("stall_g%0d", k), int'(grants4), 2);
    end
    step(4'b0100, 1'b0, 1'b0); chk("stall_drop", int'(grants4), 4);
    step(4'b0100, 1'b1, 1'b1); chk("stall_acc", int'(grants4), 4);
    step(4'b1111, 1'b0, 1'b0); chk("stall_ptr", int'(grants4), 8);

    // Overrun after max_burst_p beats without last.
    do_reset();
    for (int b = 0; b < MAXB; b++) begin
      step(4'b0010, 1'b0, 1'b1);
      chk($sformatf("ovr_g%0d", b), int'(grants4), 2);
      chk($sformatf("ovr_l%0d", b), int'(locked4), (b > 0) ? 1 : 0);
      chk($sformatf("ovr_p%0d", b), int'(ovr4), 0);
    end
    step(4'b1111, 1'b0, 1'b0);
    chk("ovr_pulse", int'(ovr4), 1); chk("ovr_unlock", int'(locked4), 0);
    chk("ovr_next", int'(grants4), 4);
    step(4'b1111, 1'b0, 1'b0); chk("ovr_clear", int'(ovr4), 0);

    // Asynchronous reset in the middle of a burst owned by requester 3.
    do_reset();
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    @(posedge clk); #1 yumi4 = 1'b0;
    #1 chk("mid_locked", int'(locked4), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_g", int'(grants4), 0);
    chk("mid_rst_l", int'(locked4), 0);
    chk("mid_rst_v", int'(v4), 0);
    @(posedge clk); #1 rst = 1'b0;
    step(4'b1111, 1'b1, 1'b0); chk("mid_after", int'(grants4), 1);

    // Constrained random: owner keeps its request up while locked.
    for (int n = 0; n < 80; n++) begin
      rr = 4'($urandom_range(0, 15));
      if (m_busy != 0) rr = rr | (4'b1 << m_owner);
      step(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    // Single-requester instance.
    @(posedge clk); #1;
    reqs1 = 1'b1; last1 = 1'b0; yumi1 = 1'b1;
    @(negedge clk);
    chk("w1_g1", int'(grants1), 1); chk("w1_t1", int'(tag1), 0); chk("w1_l1", int'(locked1), 0);
    @(posedge clk); #1 last1 = 1'b1;
    @(negedge clk);
    chk("w1_g2", int'(grants1), 1); chk("w1_t2", int'(tag1), 0); chk("w1_l2", int'(locked1), 1);
    @(posedge clk); #1 reqs1 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk("w1_v3", int'(v1), 0); chk("w1_l3", int'(locked1), 0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/bsg_arb_rr_burst_lock.md
Name: bsg_arb_rr_burst_lock

Overview:
- Round-robin arbiter that shares one downstream resource among width_p requesters.
- A grant is held for a whole multi-beat burst, from the first accepted beat until a beat accepted with last_i.
- Priority rotates per burst, not per beat.
- A beat-count limit forces release so a stuck requester cannot hold the resource forever.

Parameters:
- width_p, 4: number of requesters; must be >= 1.
- max_burst_p, 8: maximum beats per locked grant; must be >= 2.
- lg_width_lp, max(1,$clog2(width_p)): width of tag_o; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- reqs_i  in  width_p  per-requester request; must stay high for the whole burst.
- last_i  in  1  current beat of the granted requester is its last.
- yumi_i  in  1  consumer accepts the current beat; legal only when v_o=1.
- grants_o  out  width_p  one-hot grant, or zero.
- v_o  out  1  equals |grants_o.
- tag_o  out  lg_width_lp  binary index of the granted requester; 0 when v_o=0.
- locked_o  out  1  arbiter is mid-burst.
- overrun_o  out  1  one-cycle registered pulse when a burst is force-released.

Behaviour:
- State: mode_r in {IDLE, LOCKED}; owner_r (lg_width_lp bits); last_r priority pointer; cnt_r, beat counter of $clog2(max_burst_p+1) bits; overrun_r.
- Reset values (async): mode_r=IDLE, owner_r=0, last_r=width_p-1 (requester 0 highest priority), cnt_r=0, overrun_r=0.
- While reset_i=1, grants_o=0, v_o=0, tag_o=0, locked_o=0, overrun_o=0.
- IDLE grant is combinational and has zero latency:
  - Winner is the first set bit of reqs_i scanning last_r+1, last_r+2, ..., wrapping modulo width_p.
  - If reqs_i=0, then grants_o=0.
  - The grant may change with reqs_i while yumi_i=0. Nothing moves without yumi_i.
- LOCKED grant: grants_o = onehot(owner_r) & reqs_i. Other requests are ignored.
  - Owner dropping its request mid-burst is a protocol error. The result is v_o=0 with the lock held; no recovery is required.
- Transitions on a clock edge with accept = v_o & yumi_i:
  - IDLE, accept & last_i: stay IDLE; last_r<=winner; cnt_r stays 0.
  - IDLE, accept & ~last_i: go to LOCKED; owner_r<=winner; last_r<=winner; cnt_r<=1.
  - LOCKED, accept & last_i: go to IDLE; cnt_r<=0.
  - LOCKED, accept & ~last_i & cnt_r==max_burst_p-1: go to IDLE; cnt_r<=0; overrun_r<=1.
  - LOCKED, accept & ~last_i otherwise: cnt_r<=cnt_r+1.
  - No accept: all state holds.
- overrun_r clears on the next edge unless set again; a set cannot recur in the next cycle since the mode is IDLE.
- The pointer updates only on the first beat of a grant, so the next arbitration after any burst starts at owner+1.
- yumi_i with v_o=0 is ignored.
- locked_o = (mode_r==LOCKED).
- width_p=1: the scan degenerates to reqs_i[0]; tag_o is always 0; locking and overrun still operate.
- Reset asserted mid-burst: outputs clear immediately (asynchronous). After deassertion, arbitration restarts with requester 0 at highest priority.

Test Plan:
- Directed scenarios use width_p=4, max_burst_p=4 unless stated.
- Rotation: after reset, reqs_i=1111, last_i=1, yumi_i=1 for 5 cycles -> grants_o 0001, 0010, 0100, 1000, 0001; tag_o 0,1,2,3,0; locked_o stays 0.
- Burst lock: reqs_i=0101, yumi_i=1, last_i=0,0,1 -> grants_o=0001 for 3 cycles with locked_o=1 in cycles 2-3 -> next cycle grants_o=0100, locked_o=0.
- Stall and no rotation: reqs_i=0110, yumi_i=0 for 5 cycles -> grants_o=0010 throughout. Then drop reqs_i to 0100 -> grants_o=0100 the same cycle. Then yumi_i=1, last_i=1 -> pointer now 2, so reqs_i=1111 grants 1000.
- Overrun: reqs_i=0010, last_i=0, yumi_i=1 for 4 beats -> after the 4th edge locked_o=0 and overrun_o=1 for exactly one cycle. Then with reqs_i=1111 -> grants_o=0100.
- Reset mid-burst: locked with cnt_r=2 on requester 3, then assert reset_i between edges -> grants_o=0 and locked_o=0 immediately. Deassert, reqs_i=1111 -> grants_o=0001.
- width_p=1: reqs_i=1, last_i=0,1 with yumi_i=1 -> grants_o=1 both beats, tag_o=0, locked_o=1 on the second beat only. Request dropped -> v_o=0.
